// File: rtl/fifo_rd_packer_if.sv
// Output word stream of the FIFO read-side packer.
//   m_data  : packed word, lane i = bits [i*DATA_W +: DATA_W]
//   m_keep  : per-lane valid mask for m_data
//   m_valid : m_data/m_keep valid
//   m_ready : downstream accepts when m_valid && m_ready
// master = packer side, slave = downstream consumer side.
interface fifo_rd_packer_if #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
);
  logic [DATA_W*PACK-1:0] m_data;
  logic [PACK-1:0]        m_keep;
  logic                   m_valid;
  logic                   m_ready;

  modport master (output m_data, output m_keep, output m_valid, input m_ready);
  modport slave  (input m_data, input m_keep, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async byte FIFO, entirely in the rd_clk domain.
// Pops bytes (1-cycle read latency), packs PACK bytes per word (lane 0 =
// first byte popped) and presents them on a valid/ready stream. A flush
// pulse emits any partially assembled word with a per-lane keep mask.
// Ports:
//   rd_clk, rd_rst : clock, synchronous active-high reset
//   fifo_empty     : FIFO empty flag
//   fifo_out       : FIFO read data, valid the cycle after a pop
//   rd_en          : FIFO pop request (combinational)
//   flush          : 1-cycle pulse, emit pending partial word
//   m              : output word stream (master side)
//   word_cnt       : count of accepted output words (wraps)
//   busy           : any byte held, in flight, flush pending or word presented
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4,
  parameter int OUT_W  = DATA_W*PACK,
  parameter int CNT_W  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 fifo_empty,
  input  logic [DATA_W-1:0]    fifo_out,
  output logic                 rd_en,
  input  logic                 flush,
  fifo_rd_packer_if.master     m,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 busy
);

  localparam int FILL_W = $clog2(PACK+1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PACK);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  logic [1:0]        state;
  logic [FILL_W-1:0] fill;
  logic              inflight;
  logic              flush_pend;
  logic [OUT_W-1:0]  asm_q;
  logic [OUT_W-1:0]  part_data;
  logic [PACK-1:0]   part_keep;
  logic [FILL_W:0]   occ;
  logic              can_load;
  logic              accept;
  logic              load_full;
  logic              load_part;

  // Bytes already captured plus the one whose data arrives next cycle.
  assign occ      = {1'b0, fill} + {{FILL_W{1'b0}}, inflight};
  assign rd_en    = !rd_rst && !fifo_empty && !flush_pend && (occ < {1'b0, FULL});
  assign can_load = !m.m_valid || m.m_ready;
  assign accept   = m.m_valid && m.m_ready;
  assign load_full = (state == ST_FILL) && (fill == FULL) && can_load;
  assign load_part = (state == ST_EMIT) && can_load;
  assign busy     = (fill != '0) || inflight || flush_pend || m.m_valid;

  // Partial word: lanes at or beyond fill are forced to zero, so stale
  // bytes from an earlier word never leak out.
  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (FILL_W'(i) < fill) begin
        part_keep[i] = 1'b1;
        part_data[i*DATA_W +: DATA_W] = asm_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= ST_FILL;
      fill       <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      asm_q      <= '0;
      m.m_data   <= '0;
      m.m_keep   <= '0;
      m.m_valid  <= 1'b0;
      word_cnt   <= '0;
    end else begin
      inflight <= rd_en;

      // Capture never coincides with a load: loads need fill==PACK (full)
      // or the EMIT state, both of which imply no byte in flight.
      if (inflight) begin
        for (int unsigned i = 0; i < PACK; i++) begin
          if (fill == FILL_W'(i)) asm_q[i*DATA_W +: DATA_W] <= fifo_out;
        end
        fill <= fill + FILL_W'(1);
      end

      if (accept) word_cnt <= word_cnt + CNT_W'(1);

      if (load_full) begin
        m.m_data  <= asm_q;
        m.m_keep  <= '1;
        m.m_valid <= 1'b1;
        fill      <= '0;
      end else if (load_part) begin
        m.m_data  <= part_data;
        m.m_keep  <= part_keep;
        m.m_valid <= 1'b1;
        fill      <= '0;
      end else if (accept) begin
        m.m_valid <= 1'b0;
      end

      case (state)
        ST_FILL: begin
          if (flush) begin
            flush_pend <= 1'b1;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight) begin
            if (fill == '0) begin
              flush_pend <= 1'b0;
              state      <= ST_FILL;
            end else begin
              state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (can_load) begin
            flush_pend <= 1'b0;
            state      <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based FIFO model feeds the DUT,
// a byte-grouping reference model fills a scoreboard of expected words,
// and a negedge monitor compares every accepted word.
module tb_fifo_rd_packer;
  localparam int DATA_W = 8;
  localparam int PACK   = 4;
  localparam int OUT_W  = DATA_W*PACK;
  localparam int CNT_W  = 8;

  logic              rd_clk = 1'b0;
  logic              rd_rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_out = '0;
  logic              rd_en;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  word_cnt;
  logic              busy;

  fifo_rd_packer_if #(.DATA_W(DATA_W), .PACK(PACK)) sif ();

  fifo_rd_packer #(.DATA_W(DATA_W), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_empty (fifo_empty),
    .fifo_out   (fifo_out),
    .rd_en      (rd_en),
    .flush      (flush),
    .m          (sif),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int underflow = 0;
  int ready_mode = 1;
  int rden_viol = 0;
  int hold_viol = 0;
  int model_cnt = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] pend[$];
  logic [OUT_W-1:0]  exp_data[$];
  logic [PACK-1:0]   exp_keep[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // Reference: every PACK bytes written form one word, byte k of the
  // group in lane k; a flush emits whatever is left with a partial keep.
  task automatic emit_pending();
    logic [OUT_W-1:0] w;
    logic [PACK-1:0]  k;
    w = '0;
    k = '0;
    for (int i = 0; i < pend.size(); i++) begin
      w[i*DATA_W +: DATA_W] = pend[i];
      k[i] = 1'b1;
    end
    exp_data.push_back(w);
    exp_keep.push_back(k);
    pend.delete();
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    pend.push_back(b);
    if (pend.size() == PACK) emit_pending();
  endtask

  task automatic model_flush();
    if (pend.size() > 0) emit_pending();
  endtask

  task automatic wait_drain(input string name, input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (exp_data.size() == 0 && fifo_q.size() == 0 && !busy) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: not idle after %0d cycles (expected words left %0d), required idle", name, max, exp_data.size());
    end
  endtask

  // Flush only once every byte has left the FIFO and all full words
  // have been accepted, so the partial word is exactly the pending bytes.
  task automatic wait_flush_ready(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (fifo_q.size() == 0 && fifo_empty && exp_data.size() == 0) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: flush precondition not reached, got busy required idle", name);
    end
  endtask

  task automatic do_flush();
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
  endtask

  // FIFO model: 1-cycle read latency.
  always @(posedge rd_clk) begin
    if (rd_en) begin
      if (fifo_q.size() > 0) begin
        fifo_out <= fifo_q.pop_front();
        pops++;
      end else begin
        underflow++;
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  always @(posedge rd_clk) begin
    #1;
    case (ready_mode)
      0:       sif.m_ready = 1'b0;
      1:       sif.m_ready = 1'b1;
      default: sif.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;
  logic             prev_rst = 1'b1;
  logic [OUT_W-1:0] prev_d = '0;
  logic [PACK-1:0]  prev_k = '0;

  always @(negedge rd_clk) begin
    logic [OUT_W-1:0] ed;
    logic [PACK-1:0]  ek;
    if (rd_rst) begin
      model_cnt = 0;
    end else begin
      if (rd_en && fifo_empty) rden_viol++;
      if (prev_v && !prev_r && !prev_rst &&
          (sif.m_valid !== 1'b1 || sif.m_data !== prev_d || sif.m_keep !== prev_k))
        hold_viol++;
      if (sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, required no word", sif.m_data, sif.m_keep);
        end else begin
          ed = exp_data.pop_front();
          ek = exp_keep.pop_front();
          chk("word_data", 64'(sif.m_data), 64'(ed));
          chk("word_keep", 64'(sif.m_keep), 64'(ek));
        end
        chk("word_cnt_at_accept", 64'(word_cnt), 64'(model_cnt % (1 << CNT_W)));
        model_cnt++;
      end
    end
    prev_v   = sif.m_valid;
    prev_r   = sif.m_ready;
    prev_d   = sif.m_data;
    prev_k   = sif.m_keep;
    prev_rst = rd_rst;
  end

  initial begin
    // Reset state
    rd_rst = 1'b1;
    ready_mode = 1;
    repeat (3) tick();
    chk("rst_m_valid", 64'(sif.m_valid), 64'd0);
    chk("rst_m_data", 64'(sif.m_data), 64'd0);
    chk("rst_m_keep", 64'(sif.m_keep), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    rd_rst = 1'b0;
    tick();

    // Two full words, 0x11..0x88
    for (int i = 1; i <= 8; i++) push_byte(8'(8'h11 * i));
    wait_drain("t1_drain", 200);
    chk("t1_word_cnt", 64'(word_cnt), 64'd2);

    // Backpressure: 12 bytes, ready low for 20 cycles
    ready_mode = 0;
    repeat (2) tick();
    pops = 0;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h20 + i));
    repeat (20) tick();
    chk("t2_pops_in_stall", 64'(pops), 64'd8);
    chk("t2_m_valid_held", 64'(sif.m_valid), 64'd1);
    chk("t2_rd_en_stalled", 64'(rd_en), 64'd0);
    ready_mode = 1;
    wait_drain("t2_drain", 200);
    chk("t2_word_cnt", 64'(word_cnt), 64'd5);

    // Partial flush of three bytes, then a flush with nothing pending
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    wait_flush_ready("t3_pre_flush");
    do_flush();
    wait_drain("t3_drain", 200);
    do_flush();
    repeat (5) tick();
    chk("t3_empty_flush_busy", 64'(busy), 64'd0);
    chk("t3_word_cnt", 64'(word_cnt), 64'd6);

    // Flush in the same cycle as the pop of the second byte
    push_byte(8'hB1);
    repeat (3) tick();
    push_byte(8'hB2);
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("t4_drain", 200);
    chk("t4_word_cnt", 64'(word_cnt), 64'd7);

    // Reset with one word presented and two bytes assembled
    ready_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i));
    repeat (15) tick();
    chk("t5_m_valid_before_rst", 64'(sif.m_valid), 64'd1);
    rd_rst = 1'b1;
    fifo_q.delete();
    pend.delete();
    exp_data.delete();
    exp_keep.delete();
    fifo_empty = 1'b1;
    push_byte(8'hD0);
    #1;
    chk("t5_rd_en_in_rst", 64'(rd_en), 64'd0);
    tick();
    chk("t5_m_valid", 64'(sif.m_valid), 64'd0);
    chk("t5_m_data", 64'(sif.m_data), 64'd0);
    chk("t5_m_keep", 64'(sif.m_keep), 64'd0);
    chk("t5_word_cnt", 64'(word_cnt), 64'd0);
    rd_rst = 1'b0;
    push_byte(8'hD1);
    push_byte(8'hD2);
    push_byte(8'hD3);
    ready_mode = 1;
    wait_drain("t5_drain", 200);

    // Random traffic with random backpressure and random flushes
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      int n;
      n = int'($urandom_range(0, 9));
      for (int j = 0; j < n; j++) push_byte(8'($urandom));
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 3) == 0) begin
        wait_flush_ready("rand_pre_flush");
        do_flush();
      end
    end
    wait_flush_ready("rand_final_flush");
    do_flush();
    wait_drain("rand_drain", 4000);

    // Counter wrap: 2^CNT_W + 1 words after a reset
    ready_mode = 1;
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    for (int w = 0; w < (1 << CNT_W) + 1; w++)
      for (int b = 0; b < PACK; b++) push_byte(8'(w * 7 + b));
    wait_drain("t6_drain", 3000);
    chk("t6_word_cnt_wrap", 64'(word_cnt), 64'd1);

    chk("rd_en_while_empty", 64'(rden_viol), 64'd0);
    chk("hold_while_stalled", 64'(hold_viol), 64'd0);
    chk("fifo_underflow", 64'(underflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
